mux_pipe_reg: RTL and testbench
===============================

Name: mux_pipe_reg

Overview:
- Parametrised N:1 data-select stage for the 64-bit pipeline datapath.
- Selects one of N_IN operand channels and registers the result into a pipeline stage with valid/ready flow control.
- Includes a 2-entry skid buffer, so `in_ready` is registered and back-pressure never drops a beat.
- Sits between a producing stage (forwarding sources, ALU/mem results) and a consuming stage; it is the clocked, flow-controlled successor to the plain 2:1 Multiplexor.

Parameters:
- WIDTH, 64, data width of each channel and of the output.
- N_IN, 4, number of input channels (2..16, need not be a power of 2).
- SEL_W, $clog2(N_IN), select width (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_data  input  N_IN*WIDTH  packed channels; channel k = in_data[k*WIDTH +: WIDTH]
- in_sel  input  SEL_W  channel select, sampled with the beat
- in_valid  input  1  upstream beat valid
- in_ready  output  1  stage can accept a beat
- flush  input  1  synchronous pipeline flush
- out_data  output  WIDTH  registered selected data
- out_sel  output  SEL_W  select value that produced out_data
- out_valid  output  1  out_data valid
- out_ready  input  1  downstream accepts

Behaviour:
- Reset (async, active-high), all storage cleared:
  - out_valid=0, out_data=0, out_sel=0.
  - Skid entry empty, so in_ready=1.
- Accept condition is in_valid && in_ready. The select is applied combinationally at accept, and the selected word plus in_sel are stored together.
- Out-of-range select (in_sel >= N_IN): the stored data is all zeros. The beat is still accepted.
- Latency: an accepted beat appears on out_data/out_valid the cycle after acceptance (1 cycle) when the main register is free or drains that cycle.
- Storage is a main register (drives outputs) plus one skid register.
- in_ready = !skid_valid. It is a registered signal with no combinational path from out_ready.
- Per-cycle update (flush absent):
  - Main empty, or main draining (out_valid && out_ready):
    - Skid holds a beat: main <= skid and skid empties. A simultaneous accepted beat goes to skid.
    - Skid empty: main <= accepted beat if any, else main empties.
  - Main stalled (out_valid && !out_ready): an accepted beat goes to skid. It can only be accepted while skid is empty.
- Beats leave in acceptance order. No beat is duplicated or lost under any out_ready pattern.
- flush (synchronous):
  - Next cycle out_valid=0 and skid empty, so in_ready=1.
  - out_data/out_sel hold their last values; their content is don't-care when invalid.
  - A beat presented in the flush cycle is discarded even if in_ready=1.
  - Flush has priority over accept, drain and skid transfer.
- Reset mid-operation: immediate clear regardless of the clock. In-flight beats are lost.
- out_data and out_sel are stable while out_valid=1 and out_ready=0.

Optional Feature:
- Macro: MUX_PIPE_REG_SELCHK_EN.
- When defined:
  - Adds output port sel_err (1 bit), a sticky flag.
  - sel_err is set on the cycle after any accepted beat with in_sel >= N_IN.
  - It is cleared only by reset; flush does not clear it.
  - The offending beat still passes through with zero data.
- When undefined:
  - No sel_err port and no checking logic.
  - Out-of-range selects silently yield zero data.

Test Plan:
- Reset → in_ready=1, out_valid=0, out_data=0.
- Pass-through. Stimulus: WIDTH=64, N_IN=4, channels {0x123456789ABCDEF0, 0xFFFFFFFFFFFFFFFF, 0x0, 0xA5A5A5A5A5A5A5A5}, out_ready=1, in_sel 0,1,3 on consecutive cycles. Response: out_data 0x123456789ABCDEF0, 0xFFFFFFFFFFFFFFFF, 0xA5A5A5A5A5A5A5A5 one cycle later, with out_sel 0,1,3.
- Back-pressure. Stimulus: out_ready=0, two beats sel=1 then sel=3. Response:
  - Second beat accepted into skid, then in_ready=0.
  - A third beat is held off.
  - out_ready=1 releases 0xFFFF…FF then 0xA5A5…A5 in order, and in_ready returns to 1.
- Flush. Stimulus: main and skid full, flush=1 with in_valid=1 (sel=0). Response: next cycle out_valid=0, in_ready=1, and the sel=0 beat never appears.
- Out-of-range select. Stimulus: N_IN=3, in_sel=3. Response:
  - out_data=0 one cycle later.
  - With MUX_PIPE_REG_SELCHK_EN, sel_err=1 and stays 1 after flush.
  - sel_err clears only on reset.
- Async reset mid-stall. Stimulus: reset pulse between clock edges while out_valid=1. Response: out_valid=0 and in_ready=1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mux_pipe_reg.sv
// mux_pipe_reg: N_IN:1 operand select registered into a valid/ready pipeline
// stage. A main register drives the outputs and a single skid register
// absorbs the beat that arrives while the main register is stalled, so
// in_ready is a plain flop output with no path from out_ready.
//
// Optional build macro MUX_PIPE_REG_SELCHK_EN adds a sticky sel_err output
// that flags any accepted beat whose select is outside 0..N_IN-1.

module mux_pipe_reg #(
    parameter int WIDTH = 64,
    parameter int N_IN  = 4,
    parameter int SEL_W = $clog2(N_IN)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]      in_sel,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  flush,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_sel,
    output logic                  out_valid,
    input  logic                  out_ready
`ifdef MUX_PIPE_REG_SELCHK_EN
    ,
    output logic                  sel_err
`endif
);

    // Main register (drives the outputs)
    logic             main_valid_q, main_valid_d;
    logic [WIDTH-1:0] main_data_q,  main_data_d;
    logic [SEL_W-1:0] main_sel_q,   main_sel_d;

    // Skid register (second beat while main is stalled)
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] skid_data_q,  skid_data_d;
    logic [SEL_W-1:0] skid_sel_q,   skid_sel_d;

    // Selected word for the beat currently on the input
    logic [WIDTH-1:0] sel_word;

    // Beat is taken this cycle (a flushed beat is never taken)
    logic take;

    // Main register may load this cycle: empty, or its beat leaves now
    logic main_free;

    assign in_ready  = !skid_valid_q;
    assign take      = in_valid && in_ready && !flush;
    assign main_free = !main_valid_q || out_ready;

    assign out_data  = main_data_q;
    assign out_sel   = main_sel_q;
    assign out_valid = main_valid_q;

    // Channel select; a select with no matching channel yields all zeros
    always_comb begin
        sel_word = '0;
        for (int k = 0; k < N_IN; k++) begin
            if (in_sel == SEL_W'(k)) begin
                sel_word = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    // Next-state for main and skid registers; flush wins over everything
    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        main_sel_d   = main_sel_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_sel_d   = skid_sel_q;

        if (flush) begin
            // Data/select hold their values; only the valid bits drop
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (main_free) begin
            if (skid_valid_q) begin
                // Oldest beat moves up; any new beat queues behind it
                main_valid_d = 1'b1;
                main_data_d  = skid_data_q;
                main_sel_d   = skid_sel_q;
                skid_valid_d = take;
                if (take) begin
                    skid_data_d = sel_word;
                    skid_sel_d  = in_sel;
                end
            end else begin
                main_valid_d = take;
                if (take) begin
                    main_data_d = sel_word;
                    main_sel_d  = in_sel;
                end
            end
        end else begin
            // Main stalled: a taken beat can only land in the (empty) skid
            if (take) begin
                skid_valid_d = 1'b1;
                skid_data_d  = sel_word;
                skid_sel_d   = in_sel;
            end
        end
    end

    // Stage storage with asynchronous clear of every field
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            main_sel_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_sel_q   <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            main_sel_q   <= main_sel_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_sel_q   <= skid_sel_d;
        end
    end

`ifdef MUX_PIPE_REG_SELCHK_EN
    logic sel_oob;
    logic sel_err_q, sel_err_d;

    assign sel_oob = (int'(in_sel) >= N_IN);
    assign sel_err = sel_err_q;

    // Sticky error: set by any taken out-of-range beat, survives flush
    always_comb begin
        sel_err_d = sel_err_q;
        if (take && sel_oob) begin
            sel_err_d = 1'b1;
        end
    end

    // Error flag storage, cleared only by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_err_q <= 1'b0;
        end else begin
            sel_err_q <= sel_err_d;
        end
    end
`endif

endmodule

// File: tb/tb_mux_pipe_reg.sv
// Bench for mux_pipe_reg: a 4-channel and a 3-channel instance share one
// stimulus stream. The reference model treats the stage as an in-order
// queue holding at most two beats.
`timescale 1ns/1ps

module tb_mux_pipe_reg;
    localparam int W = 64;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [4*W-1:0] in_data = '0;
    logic [1:0]     in_sel = '0;
    logic           in_valid = 1'b0;
    logic           flush = 1'b0;
    logic           out_ready = 1'b0;

    logic           in_ready4, out_valid4;
    logic [W-1:0]   out_data4;
    logic [1:0]     out_sel4;
    logic           in_ready3, out_valid3;
    logic [W-1:0]   out_data3;
    logic [1:0]     out_sel3;
`ifdef MUX_PIPE_REG_SELCHK_EN
    logic           sel_err4, sel_err3;
`endif

    always #5 clk = ~clk;

    mux_pipe_reg #(.WIDTH(W), .N_IN(4)) dut4 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_sel(in_sel),
        .in_valid(in_valid), .in_ready(in_ready4), .flush(flush),
        .out_data(out_data4), .out_sel(out_sel4), .out_valid(out_valid4),
        .out_ready(out_ready)
`ifdef MUX_PIPE_REG_SELCHK_EN
        , .sel_err(sel_err4)
`endif
    );

    mux_pipe_reg #(.WIDTH(W), .N_IN(3)) dut3 (
        .clk(clk), .reset(reset), .in_data(in_data[3*W-1:0]), .in_sel(in_sel),
        .in_valid(in_valid), .in_ready(in_ready3), .flush(flush),
        .out_data(out_data3), .out_sel(out_sel3), .out_valid(out_valid3),
        .out_ready(out_ready)
`ifdef MUX_PIPE_REG_SELCHK_EN
        , .sel_err(sel_err3)
`endif
    );

    typedef struct {
        logic [63:0] d4;
        logic [63:0] d3;
        logic [1:0]  s;
    } beat_t;

    beat_t       q[$];
    logic [63:0] chans[4];
    bit          err3_m = 1'b0;
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pick(input int sel, input int n);
        return (sel < n) ? chans[sel] : 64'h0;
    endfunction

    task automatic check_outputs();
        chk("in_ready4", 64'(in_ready4), 64'(q.size() < 2));
        chk("in_ready3", 64'(in_ready3), 64'(q.size() < 2));
        chk("out_valid4", 64'(out_valid4), 64'(q.size() > 0));
        chk("out_valid3", 64'(out_valid3), 64'(q.size() > 0));
        if (q.size() > 0) begin
            chk("out_data4", out_data4, q[0].d4);
            chk("out_sel4", 64'(out_sel4), 64'(q[0].s));
            chk("out_data3", out_data3, q[0].d3);
            chk("out_sel3", 64'(out_sel3), 64'(q[0].s));
        end
`ifdef MUX_PIPE_REG_SELCHK_EN
        chk("sel_err4", 64'(sel_err4), 64'h0);
        chk("sel_err3", 64'(sel_err3), 64'(err3_m));
`endif
    endtask

    // Called at a falling edge: check, drive, advance model, wait a cycle
    task automatic cycle(input logic v, input logic [1:0] s, input logic f, input logic r);
        bit    rdy;
        beat_t b;
        check_outputs();
        in_valid  = v;
        in_sel    = s;
        flush     = f;
        out_ready = r;
        in_data   = {chans[3], chans[2], chans[1], chans[0]};
        if (f) begin
            q.delete();
        end else begin
            rdy = (q.size() < 2);
            if (q.size() > 0 && r) void'(q.pop_front());
            if (v && rdy) begin
                b.d4 = pick(int'(s), 4);
                b.d3 = pick(int'(s), 3);
                b.s  = s;
                q.push_back(b);
                if (int'(s) >= 3) err3_m = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        chans[0] = 64'h123456789ABCDEF0;
        chans[1] = 64'hFFFFFFFFFFFFFFFF;
        chans[2] = 64'h0;
        chans[3] = 64'hA5A5A5A5A5A5A5A5;

        // Power-on reset
        #1 reset = 1'b1;
        #2;
        chk("rst_in_ready", 64'(in_ready4), 64'h1);
        chk("rst_out_valid", 64'(out_valid4), 64'h0);
        chk("rst_out_data", out_data4, 64'h0);
        chk("rst_out_sel", 64'(out_sel4), 64'h0);
`ifdef MUX_PIPE_REG_SELCHK_EN
        chk("rst_sel_err3", 64'(sel_err3), 64'h0);
`endif
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Pass-through with out_ready high
        cycle(1'b1, 2'd0, 1'b0, 1'b1);
        chk("pt0_data", out_data4, 64'h123456789ABCDEF0);
        chk("pt0_sel", 64'(out_sel4), 64'h0);
        cycle(1'b1, 2'd1, 1'b0, 1'b1);
        chk("pt1_data", out_data4, 64'hFFFFFFFFFFFFFFFF);
        chk("pt1_sel", 64'(out_sel4), 64'h1);
        cycle(1'b1, 2'd3, 1'b0, 1'b1);
        chk("pt3_data", out_data4, 64'hA5A5A5A5A5A5A5A5);
        chk("pt3_sel", 64'(out_sel4), 64'h3);
        chk("oob_data3", out_data3, 64'h0);
`ifdef MUX_PIPE_REG_SELCHK_EN
        chk("oob_err3", 64'(sel_err3), 64'h1);
`endif
        cycle(1'b0, 2'd0, 1'b0, 1'b1);
        cycle(1'b0, 2'd0, 1'b1, 1'b1);
`ifdef MUX_PIPE_REG_SELCHK_EN
        chk("err3_after_flush", 64'(sel_err3), 64'h1);
`endif

        // Back-pressure: fill main and skid, hold off a third beat, release
        cycle(1'b1, 2'd1, 1'b0, 1'b0);
        cycle(1'b1, 2'd3, 1'b0, 1'b0);
        chk("bp_full_ready", 64'(in_ready4), 64'h0);
        chk("bp_head", out_data4, 64'hFFFFFFFFFFFFFFFF);
        cycle(1'b1, 2'd0, 1'b0, 1'b0);
        chk("bp_held_ready", 64'(in_ready4), 64'h0);
        chk("bp_held_head", out_data4, 64'hFFFFFFFFFFFFFFFF);
        cycle(1'b0, 2'd0, 1'b0, 1'b1);
        chk("bp_second", out_data4, 64'hA5A5A5A5A5A5A5A5);
        chk("bp_ready_back", 64'(in_ready4), 64'h1);
        cycle(1'b0, 2'd0, 1'b0, 1'b1);
        chk("bp_drained", 64'(out_valid4), 64'h0);

        // Flush with both registers full and a beat on the input
        cycle(1'b1, 2'd1, 1'b0, 1'b0);
        cycle(1'b1, 2'd3, 1'b0, 1'b0);
        cycle(1'b1, 2'd0, 1'b1, 1'b0);
        chk("fl_valid", 64'(out_valid4), 64'h0);
        chk("fl_ready", 64'(in_ready4), 64'h1);
        cycle(1'b0, 2'd0, 1'b0, 1'b1);
        cycle(1'b0, 2'd0, 1'b0, 1'b1);
        chk("fl_no_beat", 64'(out_valid4), 64'h0);

        // Asynchronous reset between clock edges while stalled
        cycle(1'b1, 2'd1, 1'b0, 1'b0);
        cycle(1'b1, 2'd3, 1'b0, 1'b0);
        chk("ar_pre_valid", 64'(out_valid4), 64'h1);
        #2 reset = 1'b1;
        #1;
        chk("ar_valid", 64'(out_valid4), 64'h0);
        chk("ar_ready", 64'(in_ready4), 64'h1);
        chk("ar_data", out_data4, 64'h0);
`ifdef MUX_PIPE_REG_SELCHK_EN
        chk("ar_err3", 64'(sel_err3), 64'h0);
`endif
        in_valid  = 1'b0;
        out_ready = 1'b1;
        flush     = 1'b0;
        q.delete();
        err3_m = 1'b0;
        #1 reset = 1'b0;
        @(negedge clk);

        // Randomized traffic against the queue model
        for (int i = 0; i < 600; i++) begin
            for (int c = 0; c < 4; c++) chans[c] = {$urandom, $urandom};
            cycle($urandom_range(0, 9) < 7,
                  2'($urandom_range(0, 3)),
                  $urandom_range(0, 19) == 0,
                  $urandom_range(0, 9) < 6);
        end
        check_outputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
